// File: rtl/keypad_pkg.sv
// Shared types and the 4x4 key map used by the keypad scanner and its debouncer.
package keypad_pkg;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HELD,
        REL
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } result_t;

    // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
    function automatic logic [3:0] key_map(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debouncer: a key is accepted after DEBOUNCE_SCANS identical single-key
// scans and re-armed only after DEBOUNCE_SCANS consecutive empty scans.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  result_t    result,
    input  logic [3:0] code,
    output logic       accept,
    output logic [3:0] accept_code
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    state_t           state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= 4'h0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (result == KEY) begin
                        cand_n = code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_n = HELD;
                            cnt_n   = '0;
                        end else begin
                            state_n = CAND;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                CAND: begin
                    if (result == KEY && code == cand) begin
                        if (cnt == CNT_LAST) begin
                            accept  = 1'b1;
                            state_n = HELD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CNT_ONE;
                        end
                    end else if (result == KEY) begin
                        cand_n = code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (result == NONE) begin
                        state_n = (DEBOUNCE_SCANS == 1) ? IDLE : REL;
                        cnt_n   = (DEBOUNCE_SCANS == 1) ? '0 : CNT_ONE;
                    end
                end
                default: begin
                    if (result != NONE) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // In IDLE the accepted code is the incoming one; in CAND it equals cand.
    assign accept_code = cand_n;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples the columns,
// debounces whole-scan results and shifts accepted hex digits into a 16-bit register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROW_TICKS      = 125000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  col_i,
    output logic [3:0]  row_o,
    output logic [3:0]  key_code_o,
    output logic        key_valid_o,
    output logic [15:0] reg_16_o
);

    localparam int unsigned TICK_W = $clog2(ROW_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ROW_TICKS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

    logic [COLS-1:0]      col_meta, col_sync;
    logic [ROW_W-1:0]     row_idx;
    logic [TICK_W-1:0]    tick;
    logic [COLS-1:0]      hit [ROWS];
    logic                 row_sample, scan_done;
    logic [ROWS*COLS-1:0] scan_bits;
    logic [4:0]           n_set;
    logic [3:0]           result_code;
    result_t              result;
    logic                 accept;
    logic [3:0]           accept_code;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    assign row_sample = (tick == TICK_LAST);
    assign scan_done  = row_sample && (row_idx == ROW_LAST);
    assign row_o      = ~(ROWS'(1) << row_idx);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            row_idx <= '0;
            tick    <= '0;
            for (int r = 0; r < ROWS; r++) hit[r] <= '0;
        end else if (row_sample) begin
            hit[row_idx] <= ~col_sync;
            row_idx      <= row_idx + ROW_W'(1);
            tick         <= '0;
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // The last row is classified straight from the synchronizer, since its hit
    // word is only being latched on the scan_done edge itself.
    always_comb begin
        scan_bits   = '0;
        n_set       = '0;
        result_code = 4'h0;
        for (int r = 0; r < ROWS; r++) begin
            scan_bits[r*COLS +: COLS] = (r == ROWS - 1) ? ~col_sync : hit[r];
        end
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (scan_bits[i]) begin
                n_set       = n_set + 5'd1;
                result_code = key_map(ROW_W'(i / COLS), COL_W'(i % COLS));
            end
        end
        if (n_set == 5'd0)      result = NONE;
        else if (n_set == 5'd1) result = KEY;
        else                    result = MULTI;
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .scan_done   (scan_done),
        .result      (result),
        .code        (result_code),
        .accept      (accept),
        .accept_code (accept_code)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            key_code_o  <= 4'h0;
            key_valid_o <= 1'b0;
            reg_16_o    <= 16'h0000;
        end else begin
            key_valid_o <= accept;
            if (accept) begin
                key_code_o <= accept_code;
                reg_16_o   <= {reg_16_o[11:0], accept_code};
            end
        end
    end

endmodule
